// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and state encoding for the VGA frame writer
package vga_pkg;

    localparam int WIDTH        = 2;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 240;
    localparam int ADDR_W_DEF   = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/vga_pos_counter.sv
// rtl/vga_pos_counter.sv - column/row/linear address counters for frame fill
module vga_pos_counter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 240,
    parameter int ADDR_W   = 18
) (
    input  logic              clk_25,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    input  logic              next_line,
    output logic [ADDR_W-1:0] addr,
    output logic              last_col,
    output logic              last_row
);
    localparam int COL_W = $clog2(H_ACTIVE);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);

    logic [COL_W-1:0]  col_q, col_d, col_b;
    logic [ROW_W-1:0]  row_q, row_d, row_b;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_b;

    // clear and advance together yield position 1 of a fresh frame
    always_comb begin
        col_b  = clear ? '0 : col_q;
        row_b  = clear ? '0 : row_q;
        addr_b = clear ? '0 : addr_q;
        col_d  = col_b;
        row_d  = row_b;
        addr_d = addr_b;
        if (next_line) begin
            col_d  = '0;
            row_d  = row_b + ROW_W'(1);
            addr_d = addr_b + ADDR_W'(1);
        end else if (advance) begin
            col_d  = col_b + COL_W'(1);
            addr_d = addr_b + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_25) begin
        if (reset) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign addr     = addr_q;
    assign last_col = (col_q == COL_W'(H_ACTIVE - 1));
    assign last_row = (row_q == ROW_W'(V_ACTIVE - 1));

endmodule

// File: rtl/vga_frame_writer.sv
// rtl/vga_frame_writer.sv - pixel stream to frame-memory writer with geometry checks
module vga_frame_writer #(
    parameter int WIDTH    = vga_pkg::WIDTH,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE_DEF,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE_DEF,
    parameter int ADDR_W   = vga_pkg::ADDR_W_DEF
) (
    input  logic              clk_25,
    input  logic              reset,
    input  logic [WIDTH-1:0]  pix_data,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic              pix_eol,
    output logic              pix_ready,
    input  logic              frame_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic              frame_done,
    output logic              err_line,
    output logic              err_sof,
    output logic [7:0]        frame_count
);
    import vga_pkg::*;

    state_t            state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              err_line_q, err_line_d;
    logic              err_sof_q, err_sof_d;
    logic [7:0]        frame_count_q, frame_count_d;

    logic              accept;
    logic              cnt_clear, cnt_adv, cnt_nl;
    logic [ADDR_W-1:0] cnt_addr;
    logic              last_col, last_row;

    vga_pos_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .ADDR_W   (ADDR_W)
    ) u_pos (
        .clk_25    (clk_25),
        .reset     (reset),
        .clear     (cnt_clear),
        .advance   (cnt_adv),
        .next_line (cnt_nl),
        .addr      (cnt_addr),
        .last_col  (last_col),
        .last_row  (last_row)
    );

    assign pix_ready = (state_q != ST_DONE);
    assign accept    = pix_valid & pix_ready;

    always_comb begin
        state_d       = state_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_done_d  = frame_done_q;
        err_line_d    = 1'b0;
        err_sof_d     = 1'b0;
        frame_count_d = frame_count_q;
        cnt_clear     = 1'b0;
        cnt_adv       = 1'b0;
        cnt_nl        = 1'b0;

        // any accepted SOF starts a frame at address 0 unless it also claims EOL
        if (accept && pix_sof) begin
            err_sof_d = (state_q == ST_WRITE);
            if (pix_eol) begin
                err_line_d = 1'b1;
                state_d    = ST_DROP;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = '0;
                wr_data_d = pix_data;
                cnt_clear = 1'b1;
                cnt_adv   = 1'b1;
                state_d   = ST_WRITE;
            end
        end else begin
            case (state_q)
                ST_WRITE: begin
                    if (accept) begin
                        if (pix_eol != last_col) begin
                            err_line_d = 1'b1;
                            state_d    = ST_DROP;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = cnt_addr;
                            wr_data_d = pix_data;
                            if (pix_eol && last_row) begin
                                cnt_clear     = 1'b1;
                                frame_done_d  = 1'b1;
                                frame_count_d = frame_count_q + 8'd1;
                                state_d       = ST_DONE;
                            end else if (pix_eol) begin
                                cnt_nl = 1'b1;
                            end else begin
                                cnt_adv = 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (frame_ack) begin
                        frame_done_d = 1'b0;
                        state_d      = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_25) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_done_q  <= 1'b0;
            err_line_q    <= 1'b0;
            err_sof_q     <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_done_q  <= frame_done_d;
            err_line_q    <= err_line_d;
            err_sof_q     <= err_sof_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_done  = frame_done_q;
    assign err_line    = err_line_q;
    assign err_sof     = err_sof_q;
    assign frame_count = frame_count_q;

endmodule
